// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the tdm_demux codebase slice
package tdm_pkg;
    typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;
    localparam int ERR_CNT_WIDTH = 8;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = 8'd255;
endpackage

// File: rtl/tdm_demux_wrap_counter.sv
// wrap_counter: SIZE-bit channel counter with load, increment and terminal count at 2**SIZE-1
module wrap_counter #(
    parameter int SIZE = 3,
    localparam int CW = SIZE > 0 ? SIZE : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);
    // load wins over increment; increment wraps naturally past 2**SIZE-1
    always_ff @(posedge clk)
        if (!reset) count <= '0;
        else if (load) count <= load_val;
        else if (inc) count <= count + 1'b1;
    assign tc = count == CW'((1 << SIZE) - 1);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: frame-aligned TDM demultiplexer; TDM_DEMUX_ERR_CNT_EN adds a saturating err_count
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int SIZE = 3,
    localparam int N = 1 << SIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic [WIDTH*N-1:0] out,
    output logic               out_valid,
    output logic               locked,
    output logic               frame_err
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0] err_count
`endif
);
    localparam int CW = SIZE > 0 ? SIZE : 1;
    localparam int SH = N > 1 ? N - 1 : 1;
    state_t state;
    logic [CW-1:0] ch;
    logic tc, sof_w, dat_w, first, complete, err, ch_inc;
    logic [WIDTH-1:0] shadow [SH];
    logic [WIDTH*N-1:0] frame;
    wrap_counter #(.SIZE(SIZE)) u_ch (
        .clk(clk),
        .reset(reset),
        .load(sof_w),
        .load_val(CW'(N > 1 ? 1 : 0)),
        .inc(ch_inc),
        .count(ch),
        .tc(tc)
    );
    // decode the accepted word against state and channel position
    always_comb begin
        sof_w = in_valid & in_sof;
        dat_w = in_valid & ~in_sof;
        first = ch == '0;
        ch_inc = dat_w && state == COLLECT && !first;
        complete = (sof_w && N == 1) || (ch_inc && tc);
        err = state == COLLECT && ((sof_w && !first) || (dat_w && first));
    end
    // assemble a full frame: shadow words in the low lanes, current word in the top lane
    always_comb begin
        frame = '0;
        for (int k = 0; k < N - 1; k++) frame[k*WIDTH +: WIDTH] = shadow[k];
        frame[(N-1)*WIDTH +: WIDTH] = in;
    end
    // state, shadow capture and registered frame publication
    always_ff @(posedge clk)
        if (!reset) begin
            state <= HUNT;
            out <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            for (int k = 0; k < SH; k++) shadow[k] <= '0;
        end else begin
            out_valid <= complete;
            frame_err <= err;
            if (complete) out <= frame;
            if (sof_w) state <= COLLECT;
            else if (err) state <= HUNT;
            if (sof_w) shadow[0] <= in;
            else if (ch_inc && !tc) shadow[ch] <= in;
        end
    assign locked = state == COLLECT;
`ifdef TDM_DEMUX_ERR_CNT_EN
    // saturating count of framing violations, cleared only by reset
    always_ff @(posedge clk)
        if (!reset) err_count <= '0;
        else if (err && err_count != ERR_CNT_MAX) err_count <= err_count + 1'b1;
`endif
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: table-driven directed checks of tdm_demux with WIDTH=3, SIZE=2
module tb_tdm_demux;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [2:0] in = '0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic [11:0] out;
    logic out_valid, locked, frame_err;
    logic [7:0] ec;
    int checks = 0;
    int errors = 0;
    int fe_seen = 0;

    typedef struct {
        logic r, v, s;
        logic [2:0] d;
        logic [11:0] eo;
        logic ov, lk, fe;
        logic [7:0] ec;
    } vec_t;
    vec_t tv[$];

    tdm_demux #(.WIDTH(3), .SIZE(2)) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
        .in_valid(in_valid),
        .in_sof(in_sof),
        .out(out),
        .out_valid(out_valid),
        .locked(locked),
        .frame_err(frame_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
        ,
        .err_count(ec)
`endif
    );
`ifndef TDM_DEMUX_ERR_CNT_EN
    assign ec = '0;
`endif

    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input logic [2:0] c3, c2, c1, c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic add(input logic r, v, s, input logic [2:0] d, input logic [11:0] eo,
                       input logic ov, lk, fe, input logic [7:0] e);
        vec_t x;
        x.r = r; x.v = v; x.s = s; x.d = d; x.eo = eo; x.ov = ov; x.lk = lk; x.fe = fe; x.ec = e;
        tv.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, v, s, input logic [2:0] d);
        @(negedge clk);
        reset = r; in_valid = v; in_sof = s; in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] f0, f1, f2, f3;
        f0 = pk(3'd3, 3'd2, 3'd1, 3'd0);
        f1 = pk(3'd7, 3'd6, 3'd5, 3'd4);
        f2 = pk(3'd4, 3'd3, 3'd2, 3'd1);
        f3 = pk(3'd4, 3'd5, 3'd6, 3'd7);
        // reset then idle
        add(0,0,0,0, 0,0,0,0, 0); add(0,0,0,0, 0,0,0,0, 0);
        for (int i = 0; i < 5; i++) add(1,0,0,0, 0,0,0,0, 0);
        // back-to-back frames
        add(1,1,1,0, 0,0,1,0, 0); add(1,1,0,1, 0,0,1,0, 0); add(1,1,0,2, 0,0,1,0, 0); add(1,1,0,3, f0,1,1,0, 0);
        add(1,1,1,4, f0,0,1,0, 0); add(1,1,0,5, f0,0,1,0, 0); add(1,1,0,6, f0,0,1,0, 0); add(1,1,0,7, f1,1,1,0, 0);
        // reset, words without sof in HUNT, then a gapped frame
        add(0,0,0,0, 0,0,0,0, 0);
        add(1,1,0,5, 0,0,0,0, 0); add(1,1,0,6, 0,0,0,0, 0);
        add(1,1,1,1, 0,0,1,0, 0); add(1,0,0,0, 0,0,1,0, 0); add(1,0,0,0, 0,0,1,0, 0);
        add(1,1,0,2, 0,0,1,0, 0); add(1,0,0,0, 0,0,1,0, 0); add(1,0,0,0, 0,0,1,0, 0);
        add(1,1,0,3, 0,0,1,0, 0); add(1,0,0,0, 0,0,1,0, 0); add(1,0,0,0, 0,0,1,0, 0);
        add(1,1,0,4, f2,1,1,0, 0); add(1,0,0,0, f2,0,1,0, 0);
        // premature sof
        add(1,1,1,1, f2,0,1,0, 0); add(1,1,0,2, f2,0,1,0, 0); add(1,1,1,7, f2,0,1,1, 1);
        add(1,1,0,6, f2,0,1,0, 1); add(1,1,0,5, f2,0,1,0, 1); add(1,1,0,4, f3,1,1,0, 1);
        // lost alignment, relock; sof without valid ignored mid-frame
        add(1,1,0,3, f3,0,0,1, 2); add(1,0,0,0, f3,0,0,0, 2);
        add(1,1,1,0, f3,0,1,0, 2); add(1,0,1,5, f3,0,1,0, 2); add(1,1,0,1, f3,0,1,0, 2);
        add(1,1,0,2, f3,0,1,0, 2); add(1,1,0,3, f0,1,1,0, 2);
        // reset mid-frame discards the partial frame
        add(1,1,1,1, f0,0,1,0, 2); add(1,1,0,2, f0,0,1,0, 2); add(0,0,0,0, 0,0,0,0, 0);
        add(1,1,0,3, 0,0,0,0, 0); add(1,1,0,4, 0,0,0,0, 0); add(1,0,0,0, 0,0,0,0, 0);

        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].v, tv[i].s, tv[i].d);
            chk($sformatf("v%0d out", i), out, tv[i].eo);
            chk($sformatf("v%0d out_valid", i), out_valid, tv[i].ov);
            chk($sformatf("v%0d locked", i), locked, tv[i].lk);
            chk($sformatf("v%0d frame_err", i), frame_err, tv[i].fe);
`ifdef TDM_DEMUX_ERR_CNT_EN
            chk($sformatf("v%0d err_count", i), ec, tv[i].ec);
`endif
        end

        // saturation: one locking sof, then 300 premature sofs
        drive(1, 1, 1, 3'd1);
        chk("sat lock", locked, 1);
        for (int i = 1; i <= 300; i++) begin
            drive(1, 1, 1, 3'(i));
            if (frame_err) fe_seen++;
`ifdef TDM_DEMUX_ERR_CNT_EN
            if (i == 254) chk("sat err_count 254", ec, 254);
            if (i == 255) chk("sat err_count 255", ec, 255);
`endif
        end
        chk("sat frame_err pulses", fe_seen, 300);
`ifdef TDM_DEMUX_ERR_CNT_EN
        chk("sat err_count final", ec, 255);
`endif
        chk("sat locked", locked, 1);
        drive(1, 0, 0, 3'd0);
        chk("sat out untouched", out, 0);
        chk("sat frame_err idle", frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
